// File: rtl/ariane_pkg.sv
// Shared types for the fetch-entry arbiter: the decode fetch entry and the arbiter output buffer.
package ariane_pkg;

    localparam int unsigned FETCH_ARB_IDX_W = 3;

    typedef struct packed {
        logic [63:0] address;
        logic [31:0] instruction;
        logic        ex_valid;
    } fetch_entry_t;

    typedef struct packed {
        logic                       valid;
        fetch_entry_t               entry;
        logic [FETCH_ARB_IDX_W-1:0] src;
    } fetch_arb_buf_t;

endpackage

// File: rtl/fetch_arb_pick.sv
// Combinational rotating-priority picker: first valid index at or above i_start, wrapping.
module fetch_arb_pick
    import ariane_pkg::*;
#(
    parameter int unsigned NR_REQ = 2
) (
    input  logic [NR_REQ-1:0]          i_valid,
    input  logic [FETCH_ARB_IDX_W-1:0] i_start,
    output logic [NR_REQ-1:0]          o_gnt,
    output logic [FETCH_ARB_IDX_W-1:0] o_idx,
    output logic                       o_any
);

    localparam int unsigned SELW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    int unsigned       w_j;
    logic [SELW-1:0]   w_sel;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        w_sel = '0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            w_j = 32'(i_start) + k;
            if (w_j >= NR_REQ) begin
                w_j = w_j - NR_REQ;
            end
            w_sel = SELW'(w_j);
            if (!o_any && i_valid[w_sel]) begin
                o_any        = 1'b1;
                o_gnt[w_sel] = 1'b1;
                o_idx        = FETCH_ARB_IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/fetch_arbiter.sv
// Arbitrates NR_REQ fetch sources into a one-entry buffer feeding decode, tagging the source.
// FETCH_ARB_RR_EN selects round-robin; otherwise fixed priority (lowest index wins).
module fetch_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NR_REQ = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  fetch_entry_t               req_entry_i [NR_REQ],
    input  logic [NR_REQ-1:0]          req_valid_i,
    output logic [NR_REQ-1:0]          req_ready_o,
    output fetch_entry_t               fetch_entry_o,
    output logic                       fetch_entry_valid_o,
    input  logic                       fetch_entry_ready_i,
    output logic [FETCH_ARB_IDX_W-1:0] src_o
);

    fetch_arb_buf_t               r_out;
    logic [FETCH_ARB_IDX_W-1:0]   w_start;
    logic [NR_REQ-1:0]            w_gnt;
    logic [FETCH_ARB_IDX_W-1:0]   w_pick;
    logic                         w_any;
    logic                         w_space;
    logic                         w_accept;
    fetch_entry_t                 w_entry;

`ifdef FETCH_ARB_RR_EN
    logic [FETCH_ARB_IDX_W-1:0]   r_rr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else if (w_accept) begin
            r_rr <= (w_pick == FETCH_ARB_IDX_W'(NR_REQ - 1)) ? '0 : w_pick + 1'b1;
        end
    end

    assign w_start = r_rr;
`else
    assign w_start = '0;
`endif

    fetch_arb_pick #(
        .NR_REQ (NR_REQ)
    ) u_pick (
        .i_valid (req_valid_i),
        .i_start (w_start),
        .o_gnt   (w_gnt),
        .o_idx   (w_pick),
        .o_any   (w_any)
    );

    assign w_space  = !r_out.valid || fetch_entry_ready_i;
    assign w_accept = w_space && w_any && !flush_i;

    always_comb begin
        req_ready_o = w_accept ? w_gnt : '0;
    end

    // Select the entry by one-hot grant so the array index never needs the wider source tag.
    always_comb begin
        w_entry = '0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            if (w_gnt[k]) begin
                w_entry = req_entry_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out <= '0;
        end else if (flush_i) begin
            r_out.valid <= 1'b0;
        end else if (w_accept) begin
            r_out.valid <= 1'b1;
            r_out.entry <= w_entry;
            r_out.src   <= w_pick;
        end else if (fetch_entry_ready_i) begin
            r_out.valid <= 1'b0;
        end
    end

    assign fetch_entry_o       = r_out.entry;
    assign fetch_entry_valid_o = r_out.valid;
    assign src_o               = r_out.src;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Scoreboard bench for fetch_arbiter with NR_REQ=3; the reference honours FETCH_ARB_RR_EN.
module tb_fetch_arbiter;
    import ariane_pkg::*;

    localparam int NR = 3;
`ifdef FETCH_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_ni = 1'b0;
    logic                       flush_i = 1'b0;
    fetch_entry_t               req_entry_i [NR];
    logic [NR-1:0]              req_valid_i = '0;
    logic [NR-1:0]              req_ready_o;
    fetch_entry_t               fetch_entry_o;
    logic                       fetch_entry_valid_o;
    logic                       fetch_entry_ready_i = 1'b0;
    logic [FETCH_ARB_IDX_W-1:0] src_o;

    fetch_arbiter #(.NR_REQ(NR)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .req_entry_i         (req_entry_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .src_o               (src_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        fetch_entry_t               e;
        logic [FETCH_ARB_IDX_W-1:0] s;
    } exp_t;

    int        errors = 0;
    int        checks = 0;
    exp_t      sb[$];
    bit        mbuf = 1'b0;
    int        rr = 0;
    bit        accept_now = 1'b0;
    logic [NR-1:0] last_rdy = '0;
    logic [NR-1:0] cur_v = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic fetch_entry_t rand_entry();
        fetch_entry_t e;
        e.address     = {$urandom, $urandom};
        e.instruction = $urandom;
        e.ex_valid    = 1'($urandom_range(0, 1));
        return e;
    endfunction

    // Winner is the valid source with the smallest forward distance from the pointer.
    function automatic int model_pick(input logic [NR-1:0] v, input int start);
        int best = -1;
        int bd = NR;
        for (int i = 0; i < NR; i++) begin
            if (v[i]) begin
                int d = (i - start + NR) % NR;
                if (d < bd) begin
                    bd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic step(input logic [NR-1:0] v, input logic rdy, input logic fl);
        int p;
        bit acc;
        logic [NR-1:0] exp_r;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (last_rdy[i]) req_entry_i[i] = rand_entry();
        end
        req_valid_i = v;
        fetch_entry_ready_i = rdy;
        flush_i = fl;
        #2;
        p = model_pick(v, rr);
        acc = (!mbuf || rdy) && (p >= 0) && !fl;
        exp_r = acc ? NR'(1 << p) : '0;
        check("req_ready", 128'(req_ready_o), 128'(exp_r));
        last_rdy = exp_r;
        accept_now = acc;
        if (fl) begin
            mbuf = 1'b0;
        end else if (acc) begin
            mbuf = 1'b1;
            sb.push_back({req_entry_i[p], FETCH_ARB_IDX_W'(p)});
            if (RR) rr = (p + 1) % NR;
        end else if (rdy) begin
            mbuf = 1'b0;
        end
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (fetch_entry_valid_o) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got valid=1 expected valid=0 at %0t", $time);
                    end else begin
                        check("out_entry", 128'({fetch_entry_o, src_o}), 128'(sb[0]));
                        if (flush_i || fetch_entry_ready_i) void'(sb.pop_front());
                    end
                end else begin
                    check("pending_count", 128'(sb.size()), 128'(accept_now ? 1 : 0));
                end
            end
        end
    end

    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        accept_now = 1'b0;
        #1;
        check("rst_valid", 128'(fetch_entry_valid_o), 128'(0));
        check("rst_src", 128'(src_o), 128'(0));
        check("rst_entry", 128'(fetch_entry_o), 128'(0));
        sb.delete();
        mbuf = 1'b0;
        rr = 0;
        last_rdy = '0;
        req_valid_i = '0;
        @(negedge clk);
        #2;
        rst_ni = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NR; i++) req_entry_i[i] = rand_entry();
        #3;
        check("init_valid", 128'(fetch_entry_valid_o), 128'(0));
        check("init_src", 128'(src_o), 128'(0));
        check("init_entry", 128'(fetch_entry_o), 128'(0));
        #9;
        rst_ni = 1'b1;

        // Two sources always valid, decode always ready.
        for (int n = 0; n < 6; n++) step(3'b011, 1'b1, 1'b0);

        // Only source 1 with a known address.
        step(3'b000, 1'b1, 1'b0);
        req_entry_i[1].address = 64'h8000_0004;
        step(3'b010, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0);
        check("addr_direct", 128'(fetch_entry_o.address), 128'(64'h8000_0004));
        check("src_direct", 128'(src_o), 128'(1));

        // Full buffer held while decode stalls.
        for (int n = 0; n < 6; n++) step(3'b011, 1'b0, 1'b0);

        // Flush against a full buffer with consume and a valid source.
        step(3'b001, 1'b1, 1'b1);
        step(3'b000, 1'b0, 1'b0);

        // Pointer wrap with a non-power-of-two source count.
        step(3'b010, 1'b1, 1'b0);
        step(3'b101, 1'b1, 1'b0);
        step(3'b101, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);

        // Asynchronous reset while holding an entry.
        step(3'b001, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0);
        reset_mid();
        step(3'b110, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);

        // Randomized traffic with well-behaved sources.
        cur_v = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (last_rdy[i] || !cur_v[i]) cur_v[i] = 1'($urandom_range(0, 1));
            end
            step(cur_v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
